// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution window scheduler.
//   conv_state_t  : scheduler FSM states
//   addr_phase_t  : selects weight-table or image-window address mapping
//   KERNEL_TAPS   : number of taps in a 3x3 kernel
//   TAP_CNT_W     : width of the tap counter (must reach KERNEL_TAPS)
//   DEFAULT_DATA_W: default pixel/weight/result width, matches muladd
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int KERNEL_TAPS    = 9;
   localparam int TAP_CNT_W      = 4;
   localparam int DEFAULT_DATA_W = 17;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      FETCH,
      COMPUTE,
      WRITE,
      DONE
   } conv_state_t;

   typedef enum logic {
      PH_KERNEL,
      PH_IMAGE
   } addr_phase_t;

endpackage

// File: rtl/conv_window_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler_if
// Bundles the three buses the scheduler sits between:
//   memory read port : mem_rd_en, mem_rd_addr, mem_rd_data (1-cycle latency)
//   muladd port      : kernel_weights, subimage, mac_en, mac_out_pix
//   output buffer    : out_wr_en, out_wr_addr, out_wr_data
// Modports:
//   master : the scheduler (drives strobes/addresses/operands)
//   slave  : the environment (memory, muladd, output buffer)
// ---------------------------------------------------------------------------
interface conv_window_scheduler_if
   import conv_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = 10
);

   logic                          mem_rd_en;
   logic [ADDR_W-1:0]             mem_rd_addr;
   logic [DATA_W-1:0]             mem_rd_data;

   logic [KERNEL_TAPS*DATA_W-1:0] kernel_weights;
   logic [KERNEL_TAPS*DATA_W-1:0] subimage;
   logic                          mac_en;
   logic [DATA_W-1:0]             mac_out_pix;

   logic                          out_wr_en;
   logic [ADDR_W-1:0]             out_wr_addr;
   logic [DATA_W-1:0]             out_wr_data;

   modport master (
      output mem_rd_en,
      output mem_rd_addr,
      input  mem_rd_data,
      output kernel_weights,
      output subimage,
      output mac_en,
      input  mac_out_pix,
      output out_wr_en,
      output out_wr_addr,
      output out_wr_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_rd_addr,
      output mem_rd_data,
      input  kernel_weights,
      input  subimage,
      input  mac_en,
      output mac_out_pix,
      input  out_wr_en,
      input  out_wr_addr,
      input  out_wr_data
   );

endinterface

// File: rtl/conv_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_addr_gen
// Purely combinational read-address generator.
//   phase : PH_KERNEL -> K_BASE + tap
//           PH_IMAGE  -> IMG_BASE + (orow + tap/3)*IMG_W + ocol + tap%3
//   orow, ocol : top-left corner of the current output window
//   tap        : tap index 0..8 (values above 8 give a don't-care address)
//   addr       : resulting word address, computed modulo 2^ADDR_W
// ---------------------------------------------------------------------------
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int IMG_W    = 5,
   parameter int K_BASE   = 0,
   parameter int IMG_BASE = 16
)(
   input  addr_phase_t          phase,
   input  logic [ADDR_W-1:0]    orow,
   input  logic [ADDR_W-1:0]    ocol,
   input  logic [TAP_CNT_W-1:0] tap,
   output logic [ADDR_W-1:0]    addr
);

   logic [ADDR_W-1:0] row_off;
   logic [ADDR_W-1:0] col_off;

   // Split the tap index into its window row and column with compares
   // instead of a divider; the tap only ever spans 0..8.
   always_comb begin
      row_off = '0;
      col_off = '0;
      if (tap < TAP_CNT_W'(3)) begin
         row_off = ADDR_W'(0);
         col_off = ADDR_W'(tap);
      end else if (tap < TAP_CNT_W'(6)) begin
         row_off = ADDR_W'(1);
         col_off = ADDR_W'(tap - TAP_CNT_W'(3));
      end else begin
         row_off = ADDR_W'(2);
         col_off = ADDR_W'(tap - TAP_CNT_W'(6));
      end
   end

   // Weights sit in a flat table; image pixels are raster-ordered with a
   // row stride of IMG_W, so the window origin plus tap offset gives the word.
   always_comb begin
      addr = '0;
      if (phase == PH_KERNEL) begin
         addr = ADDR_W'(K_BASE) + ADDR_W'(tap);
      end else begin
         addr = ADDR_W'(IMG_BASE) + (orow + row_off) * ADDR_W'(IMG_W) + ocol + col_off;
      end
   end

endmodule

// File: rtl/conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler
// Sequences one 3x3 valid convolution over an IMG_W x IMG_H image: loads the
// nine weights once, then for every output position fetches the window,
// holds the external muladd enabled for MAC_LAT cycles and writes the result
// to the output buffer in raster order.
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst   : synchronous active-low reset
//   start : one-cycle pulse, begins a run when idle (ignored otherwise)
//   busy  : high from the cycle after an accepted start until done
//   done  : one-cycle pulse after the last output write
//   bus   : conv_window_scheduler_if.master (memory read, muladd, output write)
//
// Build option:
//   CONV_RELU_EN : when defined, negative results are written as 0;
//                  timing is the same either way.
// ---------------------------------------------------------------------------
module conv_window_scheduler
   import conv_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int IMG_W    = 5,
   parameter int IMG_H    = 5,
   parameter int ADDR_W   = 10,
   parameter int K_BASE   = 0,
   parameter int IMG_BASE = 16,
   parameter int MAC_LAT  = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   conv_window_scheduler_if.master bus
);

   localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam int OUT_W = IMG_W - 2;

   conv_state_t                   state;
   conv_state_t                   state_next;

   logic [TAP_CNT_W-1:0]          tap_cnt;
   logic [LAT_W-1:0]              lat_cnt;
   logic [ADDR_W-1:0]             orow;
   logic [ADDR_W-1:0]             ocol;
   logic [KERNEL_TAPS*DATA_W-1:0] weights_q;
   logic [KERNEL_TAPS*DATA_W-1:0] window_q;

   addr_phase_t                   phase;
   logic [ADDR_W-1:0]             gen_addr;
   logic                          rd_en;
   logic                          mac_en_c;
   logic                          wr_en;
   logic                          busy_c;
   logic                          done_c;
   logic                          tap_last;
   logic                          lat_last;
   logic                          last_pos;
   logic [DATA_W-1:0]             result;

   // The tap counter runs 0..9: reads go out on 0..8 and the data returned
   // one cycle later lands on counts 1..9, so count 9 is the final capture.
   assign tap_last = (tap_cnt == TAP_CNT_W'(KERNEL_TAPS));
   assign lat_last = (lat_cnt == LAT_W'(MAC_LAT - 1));
   assign last_pos = (orow == ADDR_W'(IMG_H - 3)) && (ocol == ADDR_W'(IMG_W - 3));

   conv_addr_gen #(
      .ADDR_W   (ADDR_W),
      .IMG_W    (IMG_W),
      .K_BASE   (K_BASE),
      .IMG_BASE (IMG_BASE)
   ) u_addr_gen (
      .phase (phase),
      .orow  (orow),
      .ocol  (ocol),
      .tap   (tap_cnt),
      .addr  (gen_addr)
   );

   // State register; reset returns to IDLE from anywhere, including mid-run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and strobe decode. The strobes are also forced low while rst
   // is asserted so the reset cycle itself never issues a read or write.
   always_comb begin
      state_next = state;
      phase      = PH_KERNEL;
      rd_en      = 1'b0;
      mac_en_c   = 1'b0;
      wr_en      = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD_K;
            end
         end
         LOAD_K: begin
            busy_c = 1'b1;
            phase  = PH_KERNEL;
            rd_en  = !tap_last;
            if (tap_last) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            busy_c = 1'b1;
            phase  = PH_IMAGE;
            rd_en  = !tap_last;
            if (tap_last) begin
               state_next = COMPUTE;
            end
         end
         COMPUTE: begin
            busy_c   = 1'b1;
            mac_en_c = 1'b1;
            if (lat_last) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            busy_c     = 1'b1;
            wr_en      = 1'b1;
            state_next = last_pos ? DONE : FETCH;
         end
         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (!rst) begin
         rd_en    = 1'b0;
         mac_en_c = 1'b0;
         wr_en    = 1'b0;
         busy_c   = 1'b0;
         done_c   = 1'b0;
      end
   end

   // Counters and operand registers. Weights and window taps are captured
   // from the read data that returns one cycle after each read, so count n
   // fills slot n-1. Weights are only rewritten by the next LOAD_K, which
   // keeps them valid after a run; the window is stable through COMPUTE
   // because it only changes in FETCH.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tap_cnt   <= '0;
         lat_cnt   <= '0;
         orow      <= '0;
         ocol      <= '0;
         weights_q <= '0;
         window_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tap_cnt <= '0;
                  lat_cnt <= '0;
                  orow    <= '0;
                  ocol    <= '0;
               end
            end
            LOAD_K: begin
               for (int i = 0; i < KERNEL_TAPS; i++) begin
                  if (tap_cnt == TAP_CNT_W'(i + 1)) begin
                     weights_q[i*DATA_W +: DATA_W] <= bus.mem_rd_data;
                  end
               end
               tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
            end
            FETCH: begin
               for (int i = 0; i < KERNEL_TAPS; i++) begin
                  if (tap_cnt == TAP_CNT_W'(i + 1)) begin
                     window_q[i*DATA_W +: DATA_W] <= bus.mem_rd_data;
                  end
               end
               tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
            end
            COMPUTE: begin
               lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
            end
            WRITE: begin
               if (ocol < ADDR_W'(IMG_W - 3)) begin
                  ocol <= ocol + 1'b1;
               end else begin
                  ocol <= '0;
                  orow <= orow + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Optional rectification of the muladd result: a set sign bit means a
   // negative two's-complement value, which is clamped to zero.
`ifdef CONV_RELU_EN
   assign result = bus.mac_out_pix[DATA_W-1] ? '0 : bus.mac_out_pix;
`else
   assign result = bus.mac_out_pix;
`endif

   // Addresses and write data are zeroed whenever their strobe is low so the
   // buses sit at 0 in idle and after reset.
   assign bus.mem_rd_en      = rd_en;
   assign bus.mem_rd_addr    = rd_en ? gen_addr : '0;
   assign bus.kernel_weights = weights_q;
   assign bus.subimage       = window_q;
   assign bus.mac_en         = mac_en_c;
   assign bus.out_wr_en      = wr_en;
   assign bus.out_wr_addr    = wr_en ? (orow * ADDR_W'(OUT_W) + ocol) : '0;
   assign bus.out_wr_data    = wr_en ? result : '0;
   assign busy               = busy_c;
   assign done               = done_c;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_window_scheduler
// Drives two schedulers (MAC_LAT=1 and MAC_LAT=3) from a shared memory image,
// models the muladd and memory around them, and compares every output write
// against a reference convolution computed directly from the weight and image
// arrays.
// ---------------------------------------------------------------------------
module tb_conv_window_scheduler;

   localparam int DATA_W   = 17;
   localparam int ADDR_W   = 10;
   localparam int IMG_W    = 5;
   localparam int IMG_H    = 5;
   localparam int K_BASE   = 0;
   localparam int IMG_BASE = 16;
   localparam int LAT0     = 1;
   localparam int LAT1     = 3;
   localparam int TAPS     = 9;
   localparam int VW       = TAPS * DATA_W;
   localparam int OUTS     = (IMG_W - 2) * (IMG_H - 2);
   localparam int RUN_CYC  = 160;

   logic clk;
   logic rst;
   logic start;
   logic busy0, done0, busy1, done1;

   int cyc = 0;
   int check_count = 0;
   int error_count = 0;

   logic [DATA_W-1:0] mem [0:1023];
   logic [DATA_W-1:0] wts [TAPS];
   logic [DATA_W-1:0] img [IMG_W*IMG_H];

   logic [ADDR_W-1:0] wr_addr0 [$];
   logic [ADDR_W-1:0] wr_addr1 [$];
   logic [DATA_W-1:0] wr_data0 [$];
   logic [DATA_W-1:0] wr_data1 [$];
   int                wr_lat0  [$];
   int                wr_lat1  [$];

   int done_cnt0 = 0, done_cyc0 = 0, viol0 = 0, en_run0 = 0;
   int done_cnt1 = 0, done_cyc1 = 0, viol1 = 0, en_run1 = 0;

   int run_base0, run_base1, done_base0, done_base1, start_cyc;

   logic [DATA_W-1:0] mac_sum0, mac_sum1;

   conv_window_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
   conv_window_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

   conv_window_scheduler #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
      .K_BASE(K_BASE), .IMG_BASE(IMG_BASE), .MAC_LAT(LAT0)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .bus(bus0)
   );

   conv_window_scheduler #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
      .K_BASE(K_BASE), .IMG_BASE(IMG_BASE), .MAC_LAT(LAT1)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .bus(bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory with one-cycle read latency; idle cycles return noise so a
   // capture on the wrong cycle shows up as a wrong result.
   always @(posedge clk) begin
      if (bus0.mem_rd_en) bus0.mem_rd_data <= mem[bus0.mem_rd_addr];
      else                bus0.mem_rd_data <= DATA_W'($urandom);
      if (bus1.mem_rd_en) bus1.mem_rd_data <= mem[bus1.mem_rd_addr];
      else                bus1.mem_rd_data <= DATA_W'($urandom);
   end

   // Muladd model: the sum of products is only presented once mac_en has
   // been held for the full latency; otherwise a marker value is returned.
   always @(posedge clk) begin
      en_run0 <= bus0.mac_en ? en_run0 + 1 : 0;
      en_run1 <= bus1.mac_en ? en_run1 + 1 : 0;
   end

   always_comb begin
      mac_sum0 = '0;
      mac_sum1 = '0;
      for (int k = 0; k < TAPS; k++) begin
         mac_sum0 = mac_sum0 + DATA_W'(bus0.kernel_weights[k*DATA_W +: DATA_W] * bus0.subimage[k*DATA_W +: DATA_W]);
         mac_sum1 = mac_sum1 + DATA_W'(bus1.kernel_weights[k*DATA_W +: DATA_W] * bus1.subimage[k*DATA_W +: DATA_W]);
      end
   end

   assign bus0.mac_out_pix = (en_run0 == LAT0) ? mac_sum0 : 17'h15A5A;
   assign bus1.mac_out_pix = (en_run1 == LAT1) ? mac_sum1 : 17'h15A5A;

   // Output monitor sampling on the falling edge.
   always @(negedge clk) begin
      if (bus0.out_wr_en) begin
         wr_addr0.push_back(bus0.out_wr_addr);
         wr_data0.push_back(bus0.out_wr_data);
         wr_lat0.push_back(en_run0);
      end
      if (bus1.out_wr_en) begin
         wr_addr1.push_back(bus1.out_wr_addr);
         wr_data1.push_back(bus1.out_wr_data);
         wr_lat1.push_back(en_run1);
      end
      if (done0) begin
         done_cnt0 <= done_cnt0 + 1;
         done_cyc0 <= cyc;
      end
      if (done1) begin
         done_cnt1 <= done_cnt1 + 1;
         done_cyc1 <= cyc;
      end
      if ((bus0.mac_en && bus0.out_wr_en) || (bus0.mem_rd_en && (bus0.mac_en || bus0.out_wr_en)))
         viol0 <= viol0 + 1;
      if ((bus1.mac_en && bus1.out_wr_en) || (bus1.mem_rd_en && (bus1.mac_en || bus1.out_wr_en)))
         viol1 <= viol1 + 1;
   end

   task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference convolution straight from the weight and image arrays.
   function automatic logic [DATA_W-1:0] refPixel(input int orow, input int ocol);
      logic [DATA_W-1:0] acc;
      logic [DATA_W-1:0] prod;
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod = DATA_W'(wts[k] * img[(orow + k / 3) * IMG_W + ocol + k % 3]);
         acc  = acc + prod;
      end
`ifdef CONV_RELU_EN
      if (acc[DATA_W-1]) acc = '0;
`endif
      return acc;
   endfunction

   function automatic logic [VW-1:0] packedWeights();
      logic [VW-1:0] v;
      for (int k = 0; k < TAPS; k++) v[k*DATA_W +: DATA_W] = wts[k];
      return v;
   endfunction

   task automatic loadMemory();
      for (int k = 0; k < TAPS; k++) mem[K_BASE + k] = wts[k];
      for (int i = 0; i < IMG_W * IMG_H; i++) mem[IMG_BASE + i] = img[i];
   endtask

   task automatic randomImage();
      for (int i = 0; i < IMG_W * IMG_H; i++) img[i] = DATA_W'($urandom);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy0"}, busy0, 0);
      checkOutput({tag, "_done0"}, done0, 0);
      checkOutput({tag, "_rd_en0"}, bus0.mem_rd_en, 0);
      checkOutput({tag, "_rd_addr0"}, bus0.mem_rd_addr, 0);
      checkOutput({tag, "_wr_en0"}, bus0.out_wr_en, 0);
      checkOutput({tag, "_wr_addr0"}, bus0.out_wr_addr, 0);
      checkOutput({tag, "_wr_data0"}, bus0.out_wr_data, 0);
      checkOutput({tag, "_mac_en0"}, bus0.mac_en, 0);
      checkOutput({tag, "_weights0"}, bus0.kernel_weights, 0);
      checkOutput({tag, "_subimage0"}, bus0.subimage, 0);
      checkOutput({tag, "_busy1"}, busy1, 0);
      checkOutput({tag, "_rd_en1"}, bus1.mem_rd_en, 0);
      checkOutput({tag, "_weights1"}, bus1.kernel_weights, 0);
      checkOutput({tag, "_subimage1"}, bus1.subimage, 0);
   endtask

   // Starts a run, optionally re-pulses start at a given cycle offset, and
   // lets both instances run for a fixed bounded window.
   task automatic applyStimulus(input string tag, input int pulse_again_at);
      run_base0  = wr_addr0.size();
      run_base1  = wr_addr1.size();
      done_base0 = done_cnt0;
      done_base1 = done_cnt1;
      @(negedge clk);
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_busy_after_start0"}, busy0, 1);
      checkOutput({tag, "_busy_after_start1"}, busy1, 1);
      for (int n = 1; n < RUN_CYC; n++) begin
         start = (n == pulse_again_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic checkRun(input string tag);
      logic [DATA_W-1:0] exp_d;
      checkOutput({tag, "_writes0"}, wr_addr0.size() - run_base0, OUTS);
      checkOutput({tag, "_writes1"}, wr_addr1.size() - run_base1, OUTS);
      for (int i = 0; i < OUTS; i++) begin
         exp_d = refPixel(i / (IMG_W - 2), i % (IMG_W - 2));
         if (run_base0 + i < wr_addr0.size()) begin
            checkOutput($sformatf("%s_addr0[%0d]", tag, i), wr_addr0[run_base0 + i], i);
            checkOutput($sformatf("%s_data0[%0d]", tag, i), wr_data0[run_base0 + i], exp_d);
            checkOutput($sformatf("%s_lat0[%0d]", tag, i), wr_lat0[run_base0 + i], LAT0);
         end
         if (run_base1 + i < wr_addr1.size()) begin
            checkOutput($sformatf("%s_addr1[%0d]", tag, i), wr_addr1[run_base1 + i], i);
            checkOutput($sformatf("%s_data1[%0d]", tag, i), wr_data1[run_base1 + i], exp_d);
            checkOutput($sformatf("%s_lat1[%0d]", tag, i), wr_lat1[run_base1 + i], LAT1);
         end
      end
      checkOutput({tag, "_done_pulses0"}, done_cnt0 - done_base0, 1);
      checkOutput({tag, "_done_pulses1"}, done_cnt1 - done_base1, 1);
      checkOutput({tag, "_done_cycle0"}, done_cyc0 - start_cyc, 10 + OUTS * (11 + LAT0) + 1);
      checkOutput({tag, "_done_cycle1"}, done_cyc1 - start_cyc, 10 + OUTS * (11 + LAT1) + 1);
      checkOutput({tag, "_busy_end0"}, busy0, 0);
      checkOutput({tag, "_busy_end1"}, busy1, 0);
      checkOutput({tag, "_overlap0"}, viol0, 0);
      checkOutput({tag, "_overlap1"}, viol1, 0);
      checkOutput({tag, "_weights_kept0"}, bus0.kernel_weights, packedWeights());
      checkOutput({tag, "_weights_kept1"}, bus1.kernel_weights, packedWeights());
   endtask

   function automatic logic [DATA_W-1:0] firstData0();
      return (wr_data0.size() > run_base0) ? wr_data0[run_base0] : 'x;
   endfunction

   initial begin
      logic [DATA_W-1:0] relu_exp;
      int wb0, wb1, db0;
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkIdle("reset");

      $display("[TB] all-ones kernel over ramp image");
      for (int k = 0; k < TAPS; k++) wts[k] = 1;
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) img[r * IMG_W + c] = DATA_W'(r * 5 + c);
      loadMemory();
      applyStimulus("ones", 0);
      checkRun("ones");
      checkOutput("ones_first", firstData0(), 54);

      $display("[TB] two-tap kernel with a start pulse while busy");
      for (int k = 0; k < TAPS; k++) wts[k] = 0;
      wts[0] = 2;
      wts[1] = 1;
      randomImage();
      img[0] = 3;
      img[1] = 6;
      loadMemory();
      applyStimulus("twotap", 40);
      checkRun("twotap");
      checkOutput("twotap_first", firstData0(), 12);

      $display("[TB] negative result");
      for (int k = 0; k < TAPS; k++) wts[k] = 0;
      wts[0] = 17'h1FFFF;
      randomImage();
      img[0] = 5;
      loadMemory();
      applyStimulus("neg", 0);
      checkRun("neg");
`ifdef CONV_RELU_EN
      relu_exp = 17'h00000;
`else
      relu_exp = 17'h1FFFB;
`endif
      checkOutput("neg_first", firstData0(), relu_exp);

      $display("[TB] reset during the fourth window fetch");
      for (int k = 0; k < TAPS; k++) wts[k] = DATA_W'($urandom);
      randomImage();
      loadMemory();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkIdle("midreset");
      wb0 = wr_addr0.size();
      wb1 = wr_addr1.size();
      db0 = done_cnt0;
      repeat (30) @(negedge clk);
      checkOutput("midreset_no_writes0", wr_addr0.size() - wb0, 0);
      checkOutput("midreset_no_writes1", wr_addr1.size() - wb1, 0);
      checkOutput("midreset_no_done0", done_cnt0 - db0, 0);
      checkOutput("midreset_idle0", busy0, 0);
      applyStimulus("after_reset", 0);
      checkRun("after_reset");

      for (int t = 0; t < 3; t++) begin
         $display("[TB] random run %0d", t);
         for (int k = 0; k < TAPS; k++) wts[k] = DATA_W'($urandom);
         randomImage();
         loadMemory();
         applyStimulus($sformatf("rand%0d", t), 0);
         checkRun($sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
